// File: rtl/sys_out_collector_4x4.sv
// Realigns the diagonally skewed bottom-row outputs of the 4x4 systolic array into full result rows.
// Each column has its own FWFT FIFO, and a row is released only when every column has an entry.
module sys_out_collector_4x4 #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic [DW-1:0]   col_data_1,
    input  logic [DW-1:0]   col_data_2,
    input  logic [DW-1:0]   col_data_3,
    input  logic [DW-1:0]   col_data_4,
    input  logic            col_valid_1,
    input  logic            col_valid_2,
    input  logic            col_valid_3,
    input  logic            col_valid_4,
    output logic [4*DW-1:0] out_row,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            tile_done,
    output logic            busy,
    output logic            overflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE  = 1;
    localparam logic [AW-1:0] CNT_ONE  = 1;
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    logic [DW-1:0] col_data [4];
    logic [3:0]    col_valid;
    logic [3:0]    empty;
    logic [3:0]    full;
    logic [3:0]    push_ok;
    logic [3:0]    drop;
    logic          pop;

    assign col_data[0] = col_data_1;
    assign col_data[1] = col_data_2;
    assign col_data[2] = col_data_3;
    assign col_data[3] = col_data_4;
    assign col_valid   = {col_valid_4, col_valid_3, col_valid_2, col_valid_1};

    assign out_valid = ~|empty;
    assign pop       = out_valid & out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [DW-1:0] mem [DEPTH];
            logic [AW:0]   wr_ptr_reg;
            logic [AW:0]   rd_ptr_reg;

            assign empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                               (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
            // A full FIFO still accepts a push when the row pops in the same cycle.
            assign push_ok[gi] = col_valid[gi] & (~full[gi] | pop);
            assign drop[gi]    = col_valid[gi] & full[gi] & ~pop;

            always_ff @(posedge clk) begin
                if (push_ok[gi] && !clear) begin
                    mem[wr_ptr_reg[AW-1:0]] <= col_data[gi];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else if (clear) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push_ok[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                    if (pop)         rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                end
            end

            // Heads are gated so the row bus reads zero whenever no complete row is present.
            assign out_row[gi*DW +: DW] = out_valid ? mem[rd_ptr_reg[AW-1:0]] : '0;
        end
    endgenerate

    logic [AW-1:0] row_cnt_reg;
    state_t        state_reg;
    logic          tile_done_reg;
    logic          busy_reg;
    logic          overflow_reg;

    assign out_last     = out_valid & (row_cnt_reg == CNT_LAST);
    assign tile_done    = tile_done_reg;
    assign busy         = busy_reg;
    assign overflow_err = overflow_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (clear) begin
            overflow_reg <= 1'b0;
        end else if (|drop) begin
            overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            row_cnt_reg   <= '0;
            tile_done_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (clear) begin
            state_reg     <= S_IDLE;
            row_cnt_reg   <= '0;
            tile_done_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            tile_done_reg <= 1'b0;
            if (pop) row_cnt_reg <= row_cnt_reg + CNT_ONE;
            case (state_reg)
                S_IDLE: begin
                    if (|push_ok) begin
                        state_reg <= S_COLLECT;
                        busy_reg  <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (pop && row_cnt_reg == CNT_LAST) begin
                        state_reg     <= S_DONE;
                        tile_done_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!(&empty) || (|push_ok)) begin
                        state_reg <= S_COLLECT;
                    end else begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sys_out_collector_4x4.sv
// Directed bench for sys_out_collector_4x4: expected rows are queued as stimulus is driven
// and checked against each accepted handshake.
module tb_sys_out_collector_4x4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear;
    logic [DW-1:0]   cd [4];
    logic            cv [4];
    logic [4*DW-1:0] out_row;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            tile_done;
    logic            busy;
    logic            overflow_err;

    always #5 clk = ~clk;

    sys_out_collector_4x4 #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .col_data_1(cd[0]), .col_data_2(cd[1]), .col_data_3(cd[2]), .col_data_4(cd[3]),
        .col_valid_1(cv[0]), .col_valid_2(cv[1]), .col_valid_3(cv[2]), .col_valid_4(cv[3]),
        .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .tile_done(tile_done), .busy(busy), .overflow_err(overflow_err)
    );

    int total = 0;
    int bad   = 0;
    logic [64:0] sb [$];
    int exp_rc = 0;

    int cyc, rows_acc, row_first, last_acc, td_cnt;
    logic            valid_hist [64];
    logic            busy_hist  [64];
    logic            td_hist    [64];
    logic [4*DW-1:0] row_hist   [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_row(input int base, input int r);
        return {16'(base + 10*r + 4), 16'(base + 10*r + 3), 16'(base + 10*r + 2), 16'(base + 10*r + 1)};
    endfunction

    task automatic expect_row(input int base, input int r);
        sb.push_back({(exp_rc == DEPTH-1), exp_row(base, r)});
        exp_rc = (exp_rc + 1) % DEPTH;
    endtask

    task automatic cycle_step();
        logic [64:0] e;
        if (cyc < 64) begin
            valid_hist[cyc] = out_valid;
            busy_hist[cyc]  = busy;
            td_hist[cyc]    = tile_done;
            row_hist[cyc]   = out_row;
        end
        if (tile_done) td_cnt++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_row observed=%0h expected=none", out_row);
            end else begin
                e = sb.pop_front();
                chk("row", out_row, e[63:0]);
                chk("last", {63'd0, out_last}, {63'd0, e[64]});
                $display("row accepted cyc=%0d row=%h last=%0b", cyc, out_row, out_last);
            end
            if (rows_acc == 0) row_first = cyc;
            last_acc = cyc;
            rows_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_stats();
        cyc = 0; rows_acc = 0; row_first = -1; last_acc = -1; td_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            valid_hist[i] = 1'b0; busy_hist[i] = 1'b0; td_hist[i] = 1'b0; row_hist[i] = '0;
        end
    endtask

    task automatic run_skew(input int nrows, input int ready_from, input int ncyc);
        reset_stats();
        for (int c = 0; c < ncyc; c++) begin
            for (int j = 0; j < 4; j++) begin
                cv[j] = (c - j >= 0) && (c - j < nrows);
                cd[j] = cv[j] ? DW'(10*(c - j) + j + 1) : '0;
            end
            if (c < nrows) expect_row(0, c);
            out_ready = (c >= ready_from);
            cycle_step();
        end
        for (int j = 0; j < 4; j++) begin cv[j] = 1'b0; cd[j] = '0; end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle_step();
        clear = 1'b0;
        exp_rc = 0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin cv[j] = 1'b0; cd[j] = '0; end
        reset_stats();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_row", out_row, 64'd0);
        chk("rst_last", {63'd0, out_last}, 64'd0);
        chk("rst_tile_done", {63'd0, tile_done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_overflow", {63'd0, overflow_err}, 64'd0);

        // Skewed tile, consumer always ready
        run_skew(4, 0, 12);
        chk("skew_first_row_cyc", 64'(row_first), 64'd4);
        chk("skew_last_row_cyc", 64'(last_acc), 64'd7);
        chk("skew_td_cyc7", {63'd0, td_hist[7]}, 64'd0);
        chk("skew_td_cyc8", {63'd0, td_hist[8]}, 64'd1);
        chk("skew_td_count", 64'(td_cnt), 64'd1);
        chk("skew_busy_cyc8", {63'd0, busy_hist[8]}, 64'd1);
        chk("skew_busy_cyc9", {63'd0, busy_hist[9]}, 64'd0);
        chk("skew_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure until cycle 10
        run_skew(4, 10, 20);
        chk("bp_valid_cyc4", {63'd0, valid_hist[4]}, 64'd1);
        chk("bp_hold_cyc4", row_hist[4], exp_row(0, 0));
        chk("bp_hold_cyc9", row_hist[9], exp_row(0, 0));
        chk("bp_first_row_cyc", 64'(row_first), 64'd10);
        chk("bp_last_row_cyc", 64'(last_acc), 64'd13);
        chk("bp_td_cyc14", {63'd0, td_hist[14]}, 64'd1);
        chk("bp_no_overflow", {63'd0, overflow_err}, 64'd0);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Overflow on column 1 only
        reset_stats();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cv[0] = 1'b1;
            cd[0] = DW'(100 + 10*i);
            if (i == 4) chk("ovf_before_5th", {63'd0, overflow_err}, 64'd0);
            cycle_step();
        end
        cv[0] = 1'b0;
        chk("ovf_set", {63'd0, overflow_err}, 64'd1);
        chk("ovf_no_valid", {63'd0, out_valid}, 64'd0);
        chk("ovf_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            for (int j = 1; j < 4; j++) begin cv[j] = 1'b1; cd[j] = DW'(100 + 10*i + j); end
            expect_row(99, i);
            cycle_step();
        end
        for (int j = 0; j < 4; j++) cv[j] = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle_step();
        chk("ovf_drained", {63'd0, out_valid}, 64'd0);
        chk("ovf_sticky", {63'd0, overflow_err}, 64'd1);
        chk("ovf_sb_empty", 64'(sb.size()), 64'd0);
        out_ready = 1'b0;
        do_clear();
        chk("ovf_clear_err", {63'd0, overflow_err}, 64'd0);
        chk("ovf_clear_busy", {63'd0, busy}, 64'd0);

        // Simultaneous push and pop on full FIFOs
        reset_stats();
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin cv[j] = 1'b1; cd[j] = DW'(300 + 10*i + j + 1); end
            expect_row(300, i);
            if (i == 4) begin
                chk("fp_full_valid", {63'd0, out_valid}, 64'd1);
                out_ready = 1'b1;
            end
            cycle_step();
        end
        for (int j = 0; j < 4; j++) cv[j] = 1'b0;
        chk("fp_no_overflow", {63'd0, overflow_err}, 64'd0);
        repeat (4) cycle_step();
        chk("fp_rows", 64'(rows_acc), 64'd5);
        chk("fp_empty", {63'd0, out_valid}, 64'd0);
        chk("fp_sb_empty", 64'(sb.size()), 64'd0);
        out_ready = 1'b0;
        do_clear();

        // Back-to-back tiles
        run_skew(8, 0, 16);
        chk("b2b_rows", 64'(rows_acc), 64'd8);
        chk("b2b_td_count", 64'(td_cnt), 64'd2);
        chk("b2b_td_cyc8", {63'd0, td_hist[8]}, 64'd1);
        chk("b2b_td_cyc12", {63'd0, td_hist[12]}, 64'd1);
        chk("b2b_busy_cyc9", {63'd0, busy_hist[9]}, 64'd1);
        chk("b2b_busy_cyc13", {63'd0, busy_hist[13]}, 64'd0);
        chk("b2b_sb_empty", 64'(sb.size()), 64'd0);

        // Reset after two accepted rows
        run_skew(4, 0, 6);
        chk("mid_rows_before_rst", 64'(rows_acc), 64'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_row", out_row, 64'd0);
        chk("mid_rst_last", {63'd0, out_last}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        sb.delete();
        exp_rc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_skew(4, 0, 12);
        chk("post_rst_rows", 64'(rows_acc), 64'd4);
        chk("post_rst_td_count", 64'(td_cnt), 64'd1);
        chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
